// File: rtl/instr_fetch_decode.sv
// PDP-8 fetch/decode stage: owns the PC, fetches one word per instruction, resolves the EA and drives opcode structs to EXEC.
// Optional build macro DECODE_HALT_EN: HLT and IOT words park the stage in HALT until reset.
package instr_fetch_decode_pkg;
  typedef struct packed {
    logic        AND;
    logic        TAD;
    logic        ISZ;
    logic        DCA;
    logic        JMS;
    logic        JMP;
    logic [11:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic CLA;
    logic CLA_CLL;
    logic HLT;
  } pdp_op7_opcode_s;
endpackage

module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter logic [11:0] START_ADDR = 12'o200
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            exec_PC_load,
  input  logic [11:0]     exec_PC_value,
  output logic            ifu_rd_req,
  output logic [11:0]     ifu_rd_addr,
  input  logic [11:0]     ifu_rd_data,
  output logic [11:0]     base_addr,
  output logic [11:0]     PC_value,
  output logic            decode_valid,
  output pdp_mem_opcode_s pdp_mem_opcode,
  output pdp_op7_opcode_s pdp_op7_opcode,
  output logic            halted
);

  localparam logic [2:0] FETCH_REQ    = 3'd0;
  localparam logic [2:0] FETCH_WAIT   = 3'd1;
  localparam logic [2:0] DECODE       = 3'd2;
  localparam logic [2:0] IND_REQ      = 3'd3;
  localparam logic [2:0] IND_WAIT     = 3'd4;
  localparam logic [2:0] WAIT_STALL   = 3'd5;
  localparam logic [2:0] WAIT_UNSTALL = 3'd6;
`ifdef DECODE_HALT_EN
  localparam logic [2:0] HALT         = 3'd7;
`endif

  logic [2:0]      state_q, state_d;
  logic [11:0]     pc_q, pc_d;
  logic            rd_req_q, rd_req_d;
  logic [11:0]     rd_addr_q, rd_addr_d;
  logic [11:0]     ir_q, ir_d;
  pdp_mem_opcode_s mem_q, mem_d;
  pdp_op7_opcode_s op7_q, op7_d;
  logic            dv_q, dv_d;
  logic [11:0]     ea_direct;
`ifdef DECODE_HALT_EN
  logic            halted_q, halted_d;
`endif

  function automatic pdp_mem_opcode_s dec_mem(input logic [2:0] op, input logic [11:0] ea);
    pdp_mem_opcode_s m;
    m = '0;
    case (op)
      3'd0: m.AND = 1'b1;
      3'd1: m.TAD = 1'b1;
      3'd2: m.ISZ = 1'b1;
      3'd3: m.DCA = 1'b1;
      3'd4: m.JMS = 1'b1;
      3'd5: m.JMP = 1'b1;
      default: ;
    endcase
    if (op <= 3'd5) m.mem_inst_addr = ea;
    return m;
  endfunction

  // Only these exact microcoded words are recognised; every other 6xxx/7xxx word decodes to all-zero.
  function automatic pdp_op7_opcode_s dec_op7(input logic [11:0] w);
    pdp_op7_opcode_s o;
    o = '0;
    case (w)
      12'o7000: o.NOP     = 1'b1;
      12'o7200: o.CLA     = 1'b1;
      12'o7300: o.CLA_CLL = 1'b1;
      12'o7402: o.HLT     = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    ir_d      = ir_q;
    mem_d     = mem_q;
    op7_d     = op7_q;
    dv_d      = 1'b0;
`ifdef DECODE_HALT_EN
    halted_d  = halted_q;
`endif
    ea_direct = ir_q[7] ? {pc_q[11:7], ir_q[6:0]} : {5'b0, ir_q[6:0]};
    case (state_q)
      FETCH_REQ: begin
        rd_req_d  = 1'b1;
        rd_addr_d = pc_q;
        state_d   = FETCH_WAIT;
      end
      // rd_req_q is high in the first FETCH_WAIT cycle; data arrives the cycle after it drops.
      FETCH_WAIT: begin
        if (!rd_req_q) begin
          ir_d    = ifu_rd_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
`ifdef DECODE_HALT_EN
        if (ir_q[11:9] == 3'd6 || ir_q == 12'o7402) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else
`endif
        if (ir_q[11:9] <= 3'd5 && ir_q[8]) begin
          rd_req_d  = 1'b1;
          rd_addr_d = ea_direct;
          state_d   = IND_REQ;
        end else begin
          mem_d   = dec_mem(ir_q[11:9], ea_direct);
          op7_d   = dec_op7(ir_q);
          dv_d    = 1'b1;
          state_d = WAIT_STALL;
        end
      end
      IND_REQ: state_d = IND_WAIT;
      IND_WAIT: begin
        mem_d   = dec_mem(ir_q[11:9], ifu_rd_data);
        op7_d   = '0;
        dv_d    = 1'b1;
        state_d = WAIT_STALL;
      end
      WAIT_STALL: begin
        if (stall) state_d = WAIT_UNSTALL;
      end
      WAIT_UNSTALL: begin
        if (!stall) begin
          pc_d    = exec_PC_load ? exec_PC_value : pc_q + 12'd1;
          mem_d   = '0;
          op7_d   = '0;
          state_d = FETCH_REQ;
        end
      end
`ifdef DECODE_HALT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = FETCH_REQ;
    endcase
  end

  // Control and output registers: async reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH_REQ;
      pc_q      <= START_ADDR;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      mem_q     <= '0;
      op7_q     <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      mem_q     <= mem_d;
      op7_q     <= op7_d;
      dv_q      <= dv_d;
    end
  end

  always_ff @(posedge clk) begin
    ir_q <= ir_d;
  end

`ifdef DECODE_HALT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) halted_q <= 1'b0;
    else          halted_q <= halted_d;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign ifu_rd_req     = rd_req_q;
  assign ifu_rd_addr    = rd_addr_q;
  assign base_addr      = START_ADDR;
  assign PC_value       = pc_q;
  assign decode_valid   = dv_q;
  assign pdp_mem_opcode = mem_q;
  assign pdp_op7_opcode = op7_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: memory model, instruction-level reference model and directed program.
module tb_instr_fetch_decode;
  import instr_fetch_decode_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            stall = 1'b0;
  logic            exec_PC_load = 1'b0;
  logic [11:0]     exec_PC_value = '0;
  logic            ifu_rd_req;
  logic [11:0]     ifu_rd_addr;
  logic [11:0]     ifu_rd_data = '0;
  logic [11:0]     base_addr;
  logic [11:0]     PC_value;
  logic            decode_valid;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic            halted;

  logic [11:0] mem [4096];
  logic [11:0] mdl_pc = 12'o200;
  logic [11:0] ind_addr = '0;
  int n_chk = 0;
  int n_fail = 0;

  instr_fetch_decode #(.START_ADDR(12'o200)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .exec_PC_load(exec_PC_load), .exec_PC_value(exec_PC_value),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
    .base_addr(base_addr), .PC_value(PC_value), .decode_valid(decode_valid),
    .pdp_mem_opcode(pdp_mem_opcode), .pdp_op7_opcode(pdp_op7_opcode), .halted(halted)
  );

  always #5 clk = ~clk;

  // Registered memory: data appears the cycle after the request.
  always @(posedge clk) begin
    if (ifu_rd_req) ifu_rd_data <= mem[ifu_rd_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o required %0o (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction-level reference: what EXEC must see for the word at pc.
  function automatic void model(input logic [11:0] pc, output pdp_mem_opcode_s m,
                                output pdp_op7_opcode_s o, output int lat);
    int w, op, ea, p;
    w = mem[pc];
    p = pc;
    op = w / 512;
    m = '0;
    o = '0;
    lat = 3;
    if (op < 6) begin
      ea = w % 128;
      if ((w / 128) % 2 == 1) ea = ea + (p / 128) * 128;
      if ((w / 256) % 2 == 1) begin
        ea = mem[ea];
        lat = 5;
      end
      m.mem_inst_addr = ea[11:0];
      case (op)
        0: m.AND = 1'b1;
        1: m.TAD = 1'b1;
        2: m.ISZ = 1'b1;
        3: m.DCA = 1'b1;
        4: m.JMS = 1'b1;
        default: m.JMP = 1'b1;
      endcase
    end else if (w == 'o7000) o.NOP = 1'b1;
    else if (w == 'o7200) o.CLA = 1'b1;
    else if (w == 'o7300) o.CLA_CLL = 1'b1;
    else if (w == 'o7402) o.HLT = 1'b1;
  endfunction

  task automatic monitor();
    int cyc, fetch_cyc, lat;
    bit prev_req, got_fetch;
    pdp_mem_opcode_s em;
    pdp_op7_opcode_s eo;
    cyc = 0; fetch_cyc = 0; prev_req = 0; got_fetch = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset_n) begin
        prev_req = 0;
        got_fetch = 0;
      end else begin
        if (ifu_rd_req) begin
          chk("rd_req_back_to_back", prev_req, 0);
          if (!got_fetch) begin
            got_fetch = 1;
            fetch_cyc = cyc;
            chk("fetch_addr", ifu_rd_addr, mdl_pc);
          end else begin
            ind_addr = ifu_rd_addr;
          end
        end
        prev_req = ifu_rd_req;
        if (decode_valid) begin
          model(mdl_pc, em, eo, lat);
          chk("mem_struct", pdp_mem_opcode, em);
          chk("op7_struct", pdp_op7_opcode, eo);
          chk("pc_at_decode", PC_value, mdl_pc);
          chk("latency", cyc - fetch_cyc, lat);
          got_fetch = 0;
        end
      end
    end
  endtask

  task automatic run_instr(input bit pre, input int hold, input bit ld, input logic [11:0] ldv,
                           output pdp_mem_opcode_s m, output pdp_op7_opcode_s o);
    bit got;
    logic [11:0] exp;
    m = '0;
    o = '0;
    if (pre) stall = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (decode_valid) got = 1;
    end
    chk("decode_valid_seen", got, 1);
    if (!got) return;
    m = pdp_mem_opcode;
    o = pdp_op7_opcode;
    stall = 1'b1;
    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      chk("struct_hold", {pdp_mem_opcode, pdp_op7_opcode}, {m, o});
      chk("decode_valid_single", decode_valid, 0);
    end
    stall = 1'b0;
    exec_PC_load = ld;
    exec_PC_value = ldv;
    @(negedge clk);
    exp = ld ? ldv : mdl_pc + 12'd1;
    chk("pc_after_unstall", PC_value, exp);
    chk("struct_clear", {pdp_mem_opcode, pdp_op7_opcode}, 0);
    mdl_pc = exp;
    exec_PC_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pdp_mem_opcode_s cm;
    pdp_op7_opcode_s co;
    bit got;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'o200]  = 12'o1205;
    mem[12'o201]  = 12'o5410;
    mem[12'o010]  = 12'o0300;
    mem[12'o300]  = 12'o7200;
    mem[12'o7777] = 12'o7300;
`ifdef DECODE_HALT_EN
    mem[12'o0000] = 12'o7402;
`else
    mem[12'o0000] = 12'o6001;
`endif
    mem[12'o0001] = 12'o7402;
    mem[12'o0002] = 12'o7001;
    mem[12'o0003] = 12'o3017;
    mem[12'o0004] = 12'o0150;
    mem[12'o0005] = 12'o4610;
    mem[12'o0006] = 12'o2377;
    fork
      monitor();
    join_none

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_pc", PC_value, 12'o200);
      chk("reset_rd_req", ifu_rd_req, 0);
      chk("reset_rd_addr", ifu_rd_addr, 0);
      chk("reset_dv", decode_valid, 0);
    end
    chk("reset_structs", {pdp_mem_opcode, pdp_op7_opcode}, 0);
    chk("reset_halted", halted, 0);
    chk("base_addr", base_addr, 12'o200);
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_rd_req", ifu_rd_req, 1);
    chk("first_rd_addr", ifu_rd_addr, 12'o200);

    run_instr(0, 4, 0, 12'o0, cm, co);
    chk("tad_bit", cm.TAD, 1);
    chk("tad_ea", cm.mem_inst_addr, 12'o205);

    run_instr(0, 2, 1, 12'o300, cm, co);
    chk("jmp_ind_read_addr", ind_addr, 12'o010);
    chk("jmp_bit", cm.JMP, 1);
    chk("jmp_ea", cm.mem_inst_addr, 12'o300);

    run_instr(1, 1, 1, 12'o7777, cm, co);
    chk("cla_bit", co.CLA, 1);

    run_instr(0, 3, 0, 12'o0, cm, co);
    chk("cla_cll_bit", co.CLA_CLL, 1);
    chk("pc_wrap", mdl_pc, 12'o0000);

`ifdef DECODE_HALT_EN
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (halted) got = 1;
    end
    chk("halted_seen", got, 1);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ifu_rd_req || decode_valid || !halted || PC_value != 12'o0000)
        chk("halt_quiet", {halted, ifu_rd_req, decode_valid, PC_value}, {1'b1, 1'b0, 1'b0, 12'o0000});
    end
    chk("halt_pc", PC_value, 12'o0000);
    chk("halt_structs", {pdp_mem_opcode, pdp_op7_opcode}, 0);
`else
    run_instr(0, 1, 0, 12'o0, cm, co);
    chk("iot_zero", {cm, co}, 0);
    run_instr(0, 2, 0, 12'o0, cm, co);
    chk("hlt_bit", co.HLT, 1);
    run_instr(0, 1, 0, 12'o0, cm, co);
    chk("op7_other_zero", {cm, co}, 0);
    run_instr(1, 2, 0, 12'o0, cm, co);
    chk("dca_ea", cm.mem_inst_addr, 12'o017);
    run_instr(0, 1, 0, 12'o0, cm, co);
    chk("and_ea", cm.mem_inst_addr, 12'o150);
    run_instr(0, 1, 0, 12'o0, cm, co);
    chk("jms_ind_ea", cm.mem_inst_addr, 12'o300);
    run_instr(0, 1, 0, 12'o0, cm, co);
    chk("isz_ea", cm.mem_inst_addr, 12'o177);

    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (ifu_rd_req) got = 1;
    end
    chk("rd_req_before_reset", got, 1);
`endif

    reset_n = 1'b0;
    #1;
    chk("midreset_rd_req", ifu_rd_req, 0);
    chk("midreset_structs", {pdp_mem_opcode, pdp_op7_opcode}, 0);
    chk("midreset_dv", decode_valid, 0);
    chk("midreset_pc", PC_value, 12'o200);
    chk("midreset_halted", halted, 0);
    repeat (2) @(negedge clk);
    mdl_pc = 12'o200;
    reset_n = 1'b1;
    @(negedge clk);
    chk("refetch_rd_req", ifu_rd_req, 1);
    chk("refetch_addr", ifu_rd_addr, 12'o200);
    run_instr(0, 1, 0, 12'o0, cm, co);
    chk("refetch_tad", cm.TAD, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
